// File: rtl/rgmii_tx_scheduler.sv
// Frame-level round-robin scheduler between two AXI-Stream byte sources
// feeding the RGMII transmit interface. Each frame gets a preamble and SFD.
// After each frame there is an inter-frame gap scaled to the link speed.
// A frame interrupted by a link drop is drained from its source and discarded.
module rgmii_tx_scheduler #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES    = 12
) (
    input  logic       clk_125mhz,
    input  logic       reset_n,
    input  logic       phy_link_status,
    input  logic [1:0] phy_speed_status,
    input  logic [7:0] s0_axis_tdata,
    input  logic       s0_axis_tvalid,
    input  logic       s0_axis_tlast,
    output logic       s0_axis_tready,
    input  logic [7:0] s1_axis_tdata,
    input  logic       s1_axis_tvalid,
    input  logic       s1_axis_tlast,
    output logic       s1_axis_tready,
    output logic [7:0] tx_axis_rgmii_tdata,
    output logic       tx_axis_rgmii_tvalid,
    input  logic       tx_axis_rgmii_tready,
    output logic [1:0] grant,
    output logic       underrun,
    output logic       drop_frame
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_IFG      = 3'd4,
        ST_DROP     = 3'd5
    } state_e;

    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [10:0] IFG_1G   = 11'(IFG_BYTES);
    localparam logic [10:0] IFG_100M = 11'(IFG_BYTES * 10);
    localparam logic [10:0] IFG_10M  = 11'(IFG_BYTES * 100);

    // Gap length in clocks: one byte time is 1, 10 or 100 clocks at 1000/100/10 Mbps.
    function automatic logic [10:0] ifg_load(input logic [1:0] speed);
        logic [10:0] val;
        case (speed)
            2'd0:    val = IFG_10M;
            2'd1:    val = IFG_100M;
            default: val = IFG_1G;
        endcase
        return val;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;   // 0 = source 0, 1 = source 1
    logic [10:0] ifg_cnt_q, ifg_cnt_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic        underrun_q, underrun_d;
    logic        drop_frame_q, drop_frame_d;

    logic [7:0]  src_tdata_s;
    logic        src_tvalid_s;
    logic        src_tlast_s;
    logic        src_tready_s;

    // Select the granted source's stream; nothing is selected while grant is 0.
    always_comb begin
        src_tdata_s  = 8'h00;
        src_tvalid_s = 1'b0;
        src_tlast_s  = 1'b0;
        if (grant_q[1]) begin
            src_tdata_s  = s1_axis_tdata;
            src_tvalid_s = s1_axis_tvalid;
            src_tlast_s  = s1_axis_tlast;
        end else if (grant_q[0]) begin
            src_tdata_s  = s0_axis_tdata;
            src_tvalid_s = s0_axis_tvalid;
            src_tlast_s  = s0_axis_tlast;
        end else begin
            src_tdata_s  = 8'h00;
            src_tvalid_s = 1'b0;
            src_tlast_s  = 1'b0;
        end
    end

    assign s0_axis_tready = grant_q[0] & src_tready_s;
    assign s1_axis_tready = grant_q[1] & src_tready_s;
    assign grant          = grant_q;
    assign underrun       = underrun_q;
    assign drop_frame     = drop_frame_q;

    // Next-state logic and per-state drive of the transmit interface.
    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        last_grant_d         = last_grant_q;
        ifg_cnt_d            = ifg_cnt_q;
        pre_cnt_d            = pre_cnt_q;
        underrun_d           = 1'b0;
        drop_frame_d         = 1'b0;
        src_tready_s         = 1'b0;
        tx_axis_rgmii_tdata  = 8'h00;
        tx_axis_rgmii_tvalid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pre_cnt_d = 4'd0;
                if (phy_link_status && s0_axis_tvalid && s1_axis_tvalid) begin
                    grant_d = last_grant_q ? 2'b01 : 2'b10;
                    state_d = ST_PREAMBLE;
                end else if (phy_link_status && s0_axis_tvalid) begin
                    grant_d = 2'b01;
                    state_d = ST_PREAMBLE;
                end else if (phy_link_status && s1_axis_tvalid) begin
                    grant_d = 2'b10;
                    state_d = ST_PREAMBLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                tx_axis_rgmii_tdata  = 8'h55;
                tx_axis_rgmii_tvalid = 1'b1;
                if (!phy_link_status) begin
                    state_d = ST_DROP;
                end else if (tx_axis_rgmii_tready) begin
                    if (pre_cnt_q == PRE_LAST) begin
                        pre_cnt_d = 4'd0;
                        state_d   = ST_SFD;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_SFD: begin
                tx_axis_rgmii_tdata  = 8'hD5;
                tx_axis_rgmii_tvalid = 1'b1;
                if (!phy_link_status) begin
                    state_d = ST_DROP;
                end else if (tx_axis_rgmii_tready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_SFD;
                end
            end
            ST_DATA: begin
                tx_axis_rgmii_tdata  = src_tdata_s;
                tx_axis_rgmii_tvalid = src_tvalid_s;
                src_tready_s         = tx_axis_rgmii_tready;
                underrun_d           = ~src_tvalid_s & tx_axis_rgmii_tready;
                // A last byte that transfers wins over a simultaneous link drop.
                if (src_tvalid_s && tx_axis_rgmii_tready && src_tlast_s) begin
                    last_grant_d = grant_q[1];
                    grant_d      = 2'b00;
                    ifg_cnt_d    = ifg_load(phy_speed_status);
                    state_d      = ST_IFG;
                end else if (!phy_link_status) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q != 11'd0) begin
                    ifg_cnt_d = ifg_cnt_q - 11'd1;
                end else begin
                    ifg_cnt_d = 11'd0;
                end
                // Leaving as the count reaches 1 makes the IDLE cycle the last gap clock.
                if (ifg_cnt_q <= 11'd2) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IFG;
                end
            end
            ST_DROP: begin
                src_tready_s = 1'b1;
                if (src_tvalid_s && src_tlast_s) begin
                    drop_frame_d = 1'b1;
                    last_grant_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, counters and status pulses.
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            ifg_cnt_q    <= 11'd0;
            pre_cnt_q    <= 4'd0;
            underrun_q   <= 1'b0;
            drop_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ifg_cnt_q    <= ifg_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            underrun_q   <= underrun_d;
            drop_frame_q <= drop_frame_d;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_scheduler.sv
// Directed bench for rgmii_tx_scheduler: byte-queue source models, a
// transfer/gap monitor, and one task per scenario with inline checks.
module tb_rgmii_tx_scheduler;

    logic       clk_125mhz;
    logic       reset_n;
    logic       phy_link_status;
    logic [1:0] phy_speed_status;
    logic [7:0] s0_axis_tdata, s1_axis_tdata;
    logic       s0_axis_tvalid, s1_axis_tvalid;
    logic       s0_axis_tlast, s1_axis_tlast;
    logic       s0_axis_tready, s1_axis_tready;
    logic [7:0] tx_axis_rgmii_tdata;
    logic       tx_axis_rgmii_tvalid;
    logic       tx_axis_rgmii_tready;
    logic [1:0] grant;
    logic       underrun;
    logic       drop_frame;

    int checks;
    int errors;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] exp_q[$];
    logic [7:0] xfer_byte[$];
    logic [1:0] xfer_grant[$];
    int         gaps[$];
    int         cyc, last_high_cyc;
    bit         have_high, prev_valid;
    int         underrun_cnt, drop_cnt, s1_bad, s1_rdy_cnt, s0_drain;
    bit         s0_gap;
    int         tready_period;

    rgmii_tx_scheduler dut (
        .clk_125mhz           (clk_125mhz),
        .reset_n              (reset_n),
        .phy_link_status      (phy_link_status),
        .phy_speed_status     (phy_speed_status),
        .s0_axis_tdata        (s0_axis_tdata),
        .s0_axis_tvalid       (s0_axis_tvalid),
        .s0_axis_tlast        (s0_axis_tlast),
        .s0_axis_tready       (s0_axis_tready),
        .s1_axis_tdata        (s1_axis_tdata),
        .s1_axis_tvalid       (s1_axis_tvalid),
        .s1_axis_tlast        (s1_axis_tlast),
        .s1_axis_tready       (s1_axis_tready),
        .tx_axis_rgmii_tdata  (tx_axis_rgmii_tdata),
        .tx_axis_rgmii_tvalid (tx_axis_rgmii_tvalid),
        .tx_axis_rgmii_tready (tx_axis_rgmii_tready),
        .grant                (grant),
        .underrun             (underrun),
        .drop_frame           (drop_frame)
    );

    initial begin
        clk_125mhz = 1'b0;
        forever #4 clk_125mhz = ~clk_125mhz;
    end

    // Transmitter ready: high once every tready_period clocks.
    initial begin : tready_drv
        int tr_cnt;
        tr_cnt = 0;
        tx_axis_rgmii_tready = 1'b1;
        forever begin
            @(posedge clk_125mhz);
            #1;
            tr_cnt++;
            if (tr_cnt >= tready_period) begin
                tr_cnt = 0;
                tx_axis_rgmii_tready = 1'b1;
            end else begin
                tx_axis_rgmii_tready = 1'b0;
            end
        end
    end

    // Source 0: present queue head, pop after an accepted byte.
    initial begin : src0_model
        bit fire;
        logic [8:0] tmp;
        s0_axis_tvalid = 1'b0; s0_axis_tdata = 8'h00; s0_axis_tlast = 1'b0;
        forever begin
            @(negedge clk_125mhz);
            fire = s0_axis_tvalid && s0_axis_tready;
            @(posedge clk_125mhz);
            #2;
            if (fire && q0.size() > 0) tmp = q0.pop_front();
            if (q0.size() > 0 && !s0_gap) begin
                s0_axis_tvalid = 1'b1; s0_axis_tdata = q0[0][7:0]; s0_axis_tlast = q0[0][8];
            end else begin
                s0_axis_tvalid = 1'b0; s0_axis_tdata = 8'h00; s0_axis_tlast = 1'b0;
            end
        end
    end

    // Source 1: same behaviour, no gap control.
    initial begin : src1_model
        bit fire;
        logic [8:0] tmp;
        s1_axis_tvalid = 1'b0; s1_axis_tdata = 8'h00; s1_axis_tlast = 1'b0;
        forever begin
            @(negedge clk_125mhz);
            fire = s1_axis_tvalid && s1_axis_tready;
            @(posedge clk_125mhz);
            #2;
            if (fire && q1.size() > 0) tmp = q1.pop_front();
            if (q1.size() > 0) begin
                s1_axis_tvalid = 1'b1; s1_axis_tdata = q1[0][7:0]; s1_axis_tlast = q1[0][8];
            end else begin
                s1_axis_tvalid = 1'b0; s1_axis_tdata = 8'h00; s1_axis_tlast = 1'b0;
            end
        end
    end

    // Monitor: log transfers, tvalid-low gaps and status pulses.
    initial begin : monitor
        cyc = 0;
        forever begin
            @(negedge clk_125mhz);
            cyc++;
            if (tx_axis_rgmii_tvalid && tx_axis_rgmii_tready) begin
                xfer_byte.push_back(tx_axis_rgmii_tdata);
                xfer_grant.push_back(grant);
            end
            if (tx_axis_rgmii_tvalid) begin
                if (have_high && !prev_valid) gaps.push_back(cyc - last_high_cyc - 1);
                have_high = 1'b1;
                last_high_cyc = cyc;
            end
            prev_valid = tx_axis_rgmii_tvalid;
            if (underrun) underrun_cnt++;
            if (drop_frame) drop_cnt++;
            if (s1_axis_tready && !tx_axis_rgmii_tready) s1_bad++;
            if (s1_axis_tready) s1_rdy_cnt++;
            if (s0_axis_tready && s0_axis_tvalid && !tx_axis_rgmii_tvalid) s0_drain++;
        end
    end

    task automatic clear_logs();
        xfer_byte.delete(); xfer_grant.delete(); gaps.delete();
        have_high = 1'b0; prev_valid = 1'b0;
        underrun_cnt = 0; drop_cnt = 0; s1_bad = 0; s1_rdy_cnt = 0; s0_drain = 0;
    endtask

    task automatic setup(input logic [1:0] speed, input int period);
        reset_n = 1'b0;
        phy_link_status = 1'b1;
        phy_speed_status = speed;
        tready_period = period;
        s0_gap = 1'b0;
        repeat (2) @(posedge clk_125mhz);
        #3;
        q0.delete(); q1.delete(); exp_q.delete();
        clear_logs();
    endtask

    task automatic release_reset();
        @(posedge clk_125mhz);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic push_frame(input int src, input int n, input logic [7:0] base);
        logic [8:0] e;
        for (int k = 0; k < n; k++) begin
            e = {(k == n - 1) ? 1'b1 : 1'b0, base + 8'(k)};
            if (src == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic add_exp(input int n, input logic [7:0] base);
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < n; k++) exp_q.push_back(base + 8'(k));
    endtask

    task automatic wait_xfers(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_125mhz);
            #1;
            if (xfer_byte.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        setup(2'd2, 1);
        phy_link_status = 1'b0;
        push_frame(0, 4, 8'h01);
        @(negedge clk_125mhz); #1;
        checks++; if (tx_axis_rgmii_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b expected 0", tx_axis_rgmii_tvalid); end
        checks++; if (tx_axis_rgmii_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %02h expected 00", tx_axis_rgmii_tdata); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b expected 00", grant); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b expected 0", underrun); end
        checks++; if (drop_frame !== 1'b0) begin errors++; $display("FAIL rst_drop got %b expected 0", drop_frame); end
        checks++; if (s0_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s0_tready got %b expected 0", s0_axis_tready); end
        checks++; if (s1_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s1_tready got %b expected 0", s1_axis_tready); end
        release_reset();
        repeat (5) @(posedge clk_125mhz);
        @(negedge clk_125mhz); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL linkdown_grant got %b expected 00", grant); end
        checks++; if (tx_axis_rgmii_tvalid !== 1'b0) begin errors++; $display("FAIL linkdown_tvalid got %b expected 0", tx_axis_rgmii_tvalid); end
        checks++; if (s0_axis_tready !== 1'b0) begin errors++; $display("FAIL idle_s0_tready got %b expected 0", s0_axis_tready); end
        @(posedge clk_125mhz); #1;
        phy_link_status = 1'b1;
        @(posedge clk_125mhz);
        @(negedge clk_125mhz); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL linkup_grant got %b expected 01", grant); end
        checks++; if (tx_axis_rgmii_tdata !== 8'h55 || tx_axis_rgmii_tvalid !== 1'b1) begin errors++; $display("FAIL linkup_preamble got %02h/%b expected 55/1", tx_axis_rgmii_tdata, tx_axis_rgmii_tvalid); end
        repeat (30) @(posedge clk_125mhz);
    endtask

    task automatic test_single_frame();
        bit ok;
        logic [7:0] act;
        setup(2'd2, 1);
        push_frame(0, 64, 8'h10); push_frame(0, 4, 8'hA0);
        add_exp(64, 8'h10); add_exp(4, 8'hA0);
        release_reset();
        wait_xfers(84, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d xfers expected 84", xfer_byte.size()); end
        repeat (20) @(posedge clk_125mhz);
        checks++; if (xfer_byte.size() != 84) begin errors++; $display("FAIL single_count got %0d expected 84", xfer_byte.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < xfer_byte.size()) ? xfer_byte[i] : 8'hxx;
            checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL single_byte[%0d] got %02h expected %02h", i, act, exp_q[i]); end
        end
        for (int i = 0; i < xfer_grant.size(); i++) begin
            checks++; if (xfer_grant[i] !== 2'b01) begin errors++; $display("FAIL single_grant[%0d] got %b expected 01", i, xfer_grant[i]); end
        end
        checks++; if (gaps.size() != 1 || gaps[0] != 12) begin errors++; $display("FAIL single_ifg got %0d gaps first %0d expected 1 gap of 12", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1); end
        checks++; if (s1_rdy_cnt != 0) begin errors++; $display("FAIL single_s1_tready got %0d cycles expected 0", s1_rdy_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] act;
        logic [1:0] eg;
        setup(2'd2, 1);
        push_frame(0, 4, 8'h00); push_frame(0, 4, 8'h20); push_frame(0, 4, 8'h40);
        push_frame(1, 4, 8'h80); push_frame(1, 4, 8'hA0); push_frame(1, 4, 8'hC0);
        add_exp(4, 8'h00); add_exp(4, 8'h80); add_exp(4, 8'h20);
        add_exp(4, 8'hA0); add_exp(4, 8'h40); add_exp(4, 8'hC0);
        release_reset();
        wait_xfers(72, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d xfers expected 72", xfer_byte.size()); end
        repeat (20) @(posedge clk_125mhz);
        checks++; if (xfer_byte.size() != 72) begin errors++; $display("FAIL rr_count got %0d expected 72", xfer_byte.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < xfer_byte.size()) ? xfer_byte[i] : 8'hxx;
            eg = (((i / 12) % 2) == 0) ? 2'b01 : 2'b10;
            checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL rr_byte[%0d] got %02h expected %02h", i, act, exp_q[i]); end
            if (i < xfer_grant.size()) begin
                checks++; if (xfer_grant[i] !== eg) begin errors++; $display("FAIL rr_grant[%0d] got %b expected %b", i, xfer_grant[i], eg); end
            end
        end
        checks++; if (gaps.size() != 5) begin errors++; $display("FAIL rr_gap_count got %0d expected 5", gaps.size()); end
        for (int i = 0; i < gaps.size(); i++) begin
            checks++; if (gaps[i] != 12) begin errors++; $display("FAIL rr_gap[%0d] got %0d expected 12", i, gaps[i]); end
        end
    endtask

    task automatic test_100m();
        bit ok;
        logic [7:0] act;
        setup(2'd1, 5);
        push_frame(1, 20, 8'h30); push_frame(1, 2, 8'h60);
        add_exp(20, 8'h30); add_exp(2, 8'h60);
        release_reset();
        wait_xfers(38, 1500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL m100_timeout got %0d xfers expected 38", xfer_byte.size()); end
        repeat (30) @(posedge clk_125mhz);
        checks++; if (xfer_byte.size() != 38) begin errors++; $display("FAIL m100_count got %0d expected 38", xfer_byte.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < xfer_byte.size()) ? xfer_byte[i] : 8'hxx;
            checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL m100_byte[%0d] got %02h expected %02h", i, act, exp_q[i]); end
        end
        for (int i = 0; i < xfer_grant.size(); i++) begin
            checks++; if (xfer_grant[i] !== 2'b10) begin errors++; $display("FAIL m100_grant[%0d] got %b expected 10", i, xfer_grant[i]); end
        end
        checks++; if (gaps.size() != 1 || gaps[0] != 120) begin errors++; $display("FAIL m100_ifg got %0d gaps first %0d expected 1 gap of 120", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1); end
        checks++; if (s1_bad != 0) begin errors++; $display("FAIL m100_s1_tready_offpulse got %0d expected 0", s1_bad); end
        checks++; if (s1_rdy_cnt != 22) begin errors++; $display("FAIL m100_s1_tready_cycles got %0d expected 22", s1_rdy_cnt); end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [7:0] act;
        setup(2'd2, 1);
        push_frame(0, 20, 8'h70);
        add_exp(20, 8'h70);
        release_reset();
        wait_xfers(18, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ur_timeout_a got %0d xfers expected 18", xfer_byte.size()); end
        @(posedge clk_125mhz); #1;
        s0_gap = 1'b1;
        repeat (3) @(posedge clk_125mhz);
        #1;
        s0_gap = 1'b0;
        wait_xfers(28, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ur_timeout_b got %0d xfers expected 28", xfer_byte.size()); end
        repeat (10) @(posedge clk_125mhz);
        checks++; if (underrun_cnt != 3) begin errors++; $display("FAIL ur_pulses got %0d expected 3", underrun_cnt); end
        checks++; if (xfer_byte.size() != 28) begin errors++; $display("FAIL ur_count got %0d expected 28", xfer_byte.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < xfer_byte.size()) ? xfer_byte[i] : 8'hxx;
            checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL ur_byte[%0d] got %02h expected %02h", i, act, exp_q[i]); end
        end
    endtask

    task automatic test_link_drop();
        bit ok;
        logic [7:0] act;
        logic [1:0] eg;
        setup(2'd2, 1);
        push_frame(0, 30, 8'h00); push_frame(0, 4, 8'hE0);
        push_frame(1, 4, 8'h90);
        add_exp(5, 8'h00); add_exp(4, 8'h90); add_exp(4, 8'hE0);
        release_reset();
        wait_xfers(12, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ld_timeout_a got %0d xfers expected 12", xfer_byte.size()); end
        @(posedge clk_125mhz); #1;
        phy_link_status = 1'b0;
        @(negedge clk_125mhz); #1;
        @(negedge clk_125mhz); #1;
        checks++; if (tx_axis_rgmii_tvalid !== 1'b0) begin errors++; $display("FAIL ld_tvalid got %b expected 0", tx_axis_rgmii_tvalid); end
        repeat (35) @(posedge clk_125mhz);
        #1;
        checks++; if (xfer_byte.size() != 13) begin errors++; $display("FAIL ld_sent got %0d expected 13", xfer_byte.size()); end
        checks++; if (s0_drain != 25) begin errors++; $display("FAIL ld_drained got %0d expected 25", s0_drain); end
        checks++; if (drop_cnt != 1) begin errors++; $display("FAIL ld_drop_pulses got %0d expected 1", drop_cnt); end
        phy_link_status = 1'b1;
        wait_xfers(37, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ld_timeout_b got %0d xfers expected 37", xfer_byte.size()); end
        repeat (20) @(posedge clk_125mhz);
        checks++; if (xfer_byte.size() != 37) begin errors++; $display("FAIL ld_count got %0d expected 37", xfer_byte.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < xfer_byte.size()) ? xfer_byte[i] : 8'hxx;
            eg = (i >= 13 && i < 25) ? 2'b10 : 2'b01;
            checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL ld_byte[%0d] got %02h expected %02h", i, act, exp_q[i]); end
            if (i < xfer_grant.size()) begin
                checks++; if (xfer_grant[i] !== eg) begin errors++; $display("FAIL ld_grant[%0d] got %b expected %b", i, xfer_grant[i], eg); end
            end
        end
        checks++; if (drop_cnt != 1) begin errors++; $display("FAIL ld_drop_final got %0d expected 1", drop_cnt); end
    endtask

    task automatic test_tlast_link_drop();
        bit ok;
        logic [7:0] act;
        setup(2'd2, 1);
        push_frame(0, 4, 8'h11); push_frame(0, 4, 8'h22);
        add_exp(4, 8'h11); add_exp(4, 8'h22);
        release_reset();
        wait_xfers(11, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tl_timeout_a got %0d xfers expected 11", xfer_byte.size()); end
        @(posedge clk_125mhz); #1;
        phy_link_status = 1'b0;
        repeat (20) @(posedge clk_125mhz);
        #1;
        checks++; if (xfer_byte.size() != 12) begin errors++; $display("FAIL tl_sent got %0d expected 12", xfer_byte.size()); end
        checks++; if (drop_cnt != 0) begin errors++; $display("FAIL tl_drop_pulses got %0d expected 0", drop_cnt); end
        checks++; if (s0_drain != 0) begin errors++; $display("FAIL tl_drained got %0d expected 0", s0_drain); end
        phy_link_status = 1'b1;
        wait_xfers(24, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tl_timeout_b got %0d xfers expected 24", xfer_byte.size()); end
        repeat (10) @(posedge clk_125mhz);
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < xfer_byte.size()) ? xfer_byte[i] : 8'hxx;
            checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL tl_byte[%0d] got %02h expected %02h", i, act, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [7:0] act;
        logic [1:0] eg;
        setup(2'd2, 1);
        push_frame(0, 4, 8'h01); push_frame(0, 30, 8'h40);
        release_reset();
        wait_xfers(23, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_timeout_a got %0d xfers expected 23", xfer_byte.size()); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (tx_axis_rgmii_tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid got %b expected 0", tx_axis_rgmii_tvalid); end
        checks++; if (tx_axis_rgmii_tdata !== 8'h00) begin errors++; $display("FAIL rm_tdata got %02h expected 00", tx_axis_rgmii_tdata); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_grant got %b expected 00", grant); end
        checks++; if (s0_axis_tready !== 1'b0) begin errors++; $display("FAIL rm_s0_tready got %b expected 0", s0_axis_tready); end
        checks++; if (underrun !== 1'b0 || drop_frame !== 1'b0) begin errors++; $display("FAIL rm_pulses got %b/%b expected 0/0", underrun, drop_frame); end
        @(posedge clk_125mhz); #3;
        q0.delete(); q1.delete(); exp_q.delete();
        clear_logs();
        push_frame(0, 4, 8'h05); push_frame(1, 4, 8'h85);
        add_exp(4, 8'h05); add_exp(4, 8'h85);
        release_reset();
        wait_xfers(24, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_timeout_b got %0d xfers expected 24", xfer_byte.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < xfer_byte.size()) ? xfer_byte[i] : 8'hxx;
            eg = (i < 12) ? 2'b01 : 2'b10;
            checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL rm_byte[%0d] got %02h expected %02h", i, act, exp_q[i]); end
            if (i < xfer_grant.size()) begin
                checks++; if (xfer_grant[i] !== eg) begin errors++; $display("FAIL rm_grant[%0d] got %b expected %b", i, xfer_grant[i], eg); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        phy_link_status = 1'b0;
        phy_speed_status = 2'd2;
        tready_period = 1;
        s0_gap = 1'b0;
        clear_logs();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_100m();
        test_underrun();
        test_link_drop();
        test_tlast_link_drop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_scheduler.md
Name: rgmii_tx_scheduler

Overview:
- Frame-level round-robin arbiter between two AXI-Stream frame sources feeding the single byte-wide RGMII transmit user interface (`tx_axis_rgmii_*`).
- Prepends the 7-byte preamble and the SFD to each frame.
- Enforces a speed-scaled inter-frame gap (IFG) after each frame.
- Discards the rest of any frame in flight when the link drops.
- Sits directly upstream of the RGMII transmitter, in the `clk_125mhz` domain.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes sent before the SFD (range 1–15).
- IFG_BYTES, 12: inter-frame gap in byte times (range 1–20).

Ports:
- clk_125mhz  in  1  Sole clock.
- reset_n  in  1  Asynchronous, active-low reset.
- phy_link_status  in  1  Link up (1) / down (0); already synchronous to clk_125mhz.
- phy_speed_status  in  2  0 = 10 Mbps, 1 = 100 Mbps, 2 = 1000 Mbps; 3 is treated as 1000.
- s0_axis_tdata / s1_axis_tdata  in  8  Source frame bytes.
- s0_axis_tvalid / s1_axis_tvalid  in  1  Source byte valid.
- s0_axis_tlast / s1_axis_tlast  in  1  Last byte of frame.
- s0_axis_tready / s1_axis_tready  out  1  Source byte accepted.
- tx_axis_rgmii_tdata  out  8  Byte to the RGMII transmitter.
- tx_axis_rgmii_tvalid  out  1  Byte valid.
- tx_axis_rgmii_tready  in  1  Transmitter ready; may pulse once per 5 or 50 clocks at 100/10 Mbps.
- grant  out  2  One-hot source currently owning the link; 0 when none.
- underrun  out  1  One-cycle pulse, see DATA state.
- drop_frame  out  1  One-cycle pulse when a discarded frame completes.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE; grant = 0; last_grant = source 1, so source 0 wins the first tie.
  - every output 0; IFG counter 0.
- Handshake rules:
  - A downstream transfer occurs when tvalid and tready are both high.
  - tvalid, once raised, holds with tdata stable until the transfer.
- IDLE:
  - Stay here while phy_link_status = 0.
  - Otherwise, if exactly one sN_axis_tvalid is high, grant that source.
  - If both are high, grant the source other than last_grant.
  - Grant is registered; go to PREAMBLE on the next cycle.
  - No source tready is asserted in IDLE.
- PREAMBLE:
  - Drive 0x55 with tvalid = 1.
  - Count transfers; after PREAMBLE_LEN transfers go to SFD.
- SFD:
  - Drive 0xD5 with tvalid = 1; one transfer, then go to DATA.
- DATA (combinational pass-through):
  - tdata = granted source tdata.
  - tvalid = granted source tvalid.
  - Granted source tready = tx_axis_rgmii_tready. The non-granted source's tready is 0.
  - On a transfer with tlast = 1: last_grant ← grant, grant ← 0, load the IFG counter, go to IFG.
  - Source tvalid low while the transmitter is ready (tx_axis_rgmii_tready = 1) pulses underrun for one cycle. The frame still stalls and continues when valid returns.
- IFG:
  - tvalid = 0. Counter load value = IFG_BYTES × 1 / 10 / 100 at 1000 / 100 / 10 Mbps; 11-bit counter.
  - Decrement every clock; go to IDLE on the cycle the counter reaches 1.
  - phy_speed_status is sampled only at load.
- Link drop (phy_link_status = 0) during PREAMBLE, SFD or DATA:
  - Next cycle enter DROP; tvalid = 0 immediately.
- DROP:
  - Granted source tready = 1 until a byte with tvalid & tlast is consumed.
  - Then pulse drop_frame, set last_grant ← grant, grant ← 0, go to IDLE. No IFG.
  - Entered from PREAMBLE/SFD, where no source byte has been taken yet, the whole frame is drained.
- Link drop during IFG: the countdown still completes.
- Speed change mid-frame: the scheduler is unaffected; the transmitter handles pacing.
- Simultaneous tlast transfer and link drop in the same cycle: the frame counts as completed normally. Go to IFG; no drop_frame.
- Reset mid-frame: immediate return to the reset state. The source must restart its frame.

Test Plan:
- 1000 Mbps, tready tied 1, s0 sends 64-byte frame → output 55×7, D5, then 64 bytes in order on consecutive cycles; tvalid low for exactly 12 cycles; grant = 01 during frame.
- Both sources valid from reset, 1000 Mbps, 3 frames each → order s0, s1, s0, s1, s0, s1; 12-cycle gap between frames; no byte interleaving.
- 100 Mbps, tready pulses every 5th clock, 20-byte frame from s1 → 28 transfers, all bytes intact; IFG = 120 clocks; s1_axis_tready only high on pulse cycles.
- s0 drops tvalid for 3 cycles at byte 10 (tready 1) → underrun pulses 3 times; frame resumes; byte count unchanged.
- Link drop at data byte 5 of a 30-byte s0 frame → tvalid 0 next cycle; remaining 25 bytes drained with s0 tready = 1; drop_frame pulses once; next grant goes to s1 if valid.
- reset_n asserted mid-DATA, no clock edge → all outputs 0 immediately; after release, the first tie is granted to s0.
